// File: rtl/food_map_if.sv
// Signal bundle between the pellet/score store and the game, ROM and renderer.
// No valid/ready pairs here: eat_tick and restart are single-cycle pulses, and reads are fixed 1-cycle latency.
interface food_map_if #(parameter int COLS = 80);
  logic            restart;
  logic [5:0]      map_idx_y;
  logic [COLS-1:0] map_row;
  logic [5:0]      food_idx_y;
  logic [COLS-1:0] food_row;
  logic [10:0]     pacman_blkpos_x;
  logic [9:0]      pacman_blkpos_y;
  logic            eat_tick;
  logic [15:0]     score;
  logic [11:0]     food_left;
  logic            init_done;
  logic            all_eaten;
  logic [1:0]      fsm_state;

  modport store (
    input  restart, map_row, food_idx_y, pacman_blkpos_x, pacman_blkpos_y, eat_tick,
    output map_idx_y, food_row, score, food_left, init_done, all_eaten, fsm_state
  );

  modport game (
    output restart, map_row, food_idx_y, pacman_blkpos_x, pacman_blkpos_y, eat_tick,
    input  map_idx_y, food_row, score, food_left, init_done, all_eaten, fsm_state
  );
endinterface

// File: rtl/food_map_store.sv
// Pellet bitmap plus BCD score: loads from the maze ROM, serves renderer rows,
// and clears the pellet under pacman on each eat tick.
module food_map_store #(
  parameter int ROWS       = 50,
  parameter int COLS       = 80,
  parameter int TILE_SHIFT = 4
) (
  input logic       clk,
  input logic       rst_n,
  food_map_if.store bus
);
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, EAT = 2'd2} state_t;

  localparam logic [5:0]      ROWS_Y  = 6'(ROWS);
  localparam logic [11:0]     COLS_X  = 12'(COLS);
  localparam logic [10:0]     ROWS_T  = 11'(ROWS);
  localparam logic [COLS-1:0] ONE_BIT = {{(COLS-1){1'b0}}, 1'b1};

  state_t          state;
  logic [5:0]      cnt;
  logic [6:0]      tx_q;
  logic [5:0]      ty_q;
  logic [COLS-1:0] pellet [ROWS];

  logic [11:0]     cx;
  logic [10:0]     cy;
  logic [11:0]     tx;
  logic [10:0]     ty;
  logic            tile_ok;
  logic [COLS-1:0] cur_row;
  logic            mem_we;
  logic [5:0]      mem_wa;
  logic [COLS-1:0] mem_wd;

  function automatic logic [11:0] popcount(input logic [COLS-1:0] v);
    logic [11:0] c;
    c = 12'd0;
    for (int i = 0; i < COLS; i++) c = c + {11'd0, v[i]};
    return c;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
          else begin
            r[4*d +: 4] = r[4*d +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Tile under the sprite centre; widened adds so the far edge cannot wrap back into range.
  assign cx      = {1'b0, bus.pacman_blkpos_x} + 12'd8;
  assign cy      = {1'b0, bus.pacman_blkpos_y} + 11'd8;
  assign tx      = cx >> TILE_SHIFT;
  assign ty      = cy >> TILE_SHIFT;
  assign tile_ok = (tx < COLS_X) && (ty < ROWS_T);
  assign cur_row = pellet[ty_q];
  assign bus.fsm_state = state;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt - 6'd1;
    mem_wd = bus.map_row;
    if (!bus.restart) begin
      if (state == INIT && cnt != 6'd0) begin
        mem_we = 1'b1;
      end else if (state == EAT && cur_row[tx_q]) begin
        mem_we = 1'b1;
        mem_wa = ty_q;
        mem_wd = cur_row & ~(ONE_BIT << tx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) pellet[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      cnt           <= 6'd0;
      tx_q          <= 7'd0;
      ty_q          <= 6'd0;
      bus.map_idx_y <= 6'd0;
      bus.food_row  <= '0;
      bus.score     <= 16'h0000;
      bus.food_left <= 12'd0;
      bus.init_done <= 1'b0;
      bus.all_eaten <= 1'b0;
    end else if (bus.restart) begin
      state         <= INIT;
      cnt           <= 6'd0;
      bus.map_idx_y <= 6'd0;
      bus.food_row  <= '0;
      bus.score     <= 16'h0000;
      bus.food_left <= 12'd0;
      bus.init_done <= 1'b0;
      bus.all_eaten <= 1'b0;
    end else begin
      bus.food_row  <= (bus.init_done && bus.food_idx_y < ROWS_Y) ? pellet[bus.food_idx_y] : '0;
      bus.all_eaten <= bus.init_done && (bus.food_left == 12'd0);
      case (state)
        INIT: begin
          // ROM data lags the address by one cycle, so cnt=k writes row k-1.
          if (cnt != 6'd0) bus.food_left <= bus.food_left + popcount(bus.map_row);
          if (cnt == ROWS_Y) begin
            state         <= RUN;
            bus.init_done <= 1'b1;
            bus.map_idx_y <= 6'd0;
          end else begin
            cnt           <= cnt + 6'd1;
            bus.map_idx_y <= (cnt == ROWS_Y - 6'd1) ? 6'd0 : cnt + 6'd1;
          end
        end
        RUN: begin
          if (bus.eat_tick && tile_ok) begin
            tx_q  <= tx[6:0];
            ty_q  <= ty[5:0];
            state <= EAT;
          end
        end
        EAT: begin
          if (cur_row[tx_q]) begin
            bus.score <= bcd_inc(bus.score);
            if (bus.food_left != 12'd0) bus.food_left <= bus.food_left - 12'd1;
          end
          state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_food_map_store.sv
// Bench for food_map_store: registered ROM model, pellet/score model and result queues.
module tb_food_map_store;
  localparam int ROWS = 50;
  localparam int COLS = 80;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_EAT  = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  food_map_if #(.COLS(COLS)) fm_bus();

  food_map_store #(.ROWS(ROWS), .COLS(COLS), .TILE_SHIFT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fm_bus)
  );

  int          rom_mode = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_running = 1'b0;
  logic [79:0] model_map [ROWS];
  logic [15:0] m_score;
  logic [11:0] m_left;
  logic [79:0] row_q[$];
  logic [27:0] eat_q[$];

  function automatic logic [79:0] rom_data(input int r);
    logic [79:0] one;
    one = 80'h1;
    if (rom_mode == 1) return {80{1'b1}};
    return one << (r % 80);
  endfunction

  always_ff @(posedge clk) fm_bus.map_row <= rom_data(int'(fm_bus.map_idx_y));

  function automatic logic [15:0] score_plus_one(input logic [15:0] b);
    int v;
    logic [15:0] r;
    v = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]) + 1;
    if (v > 9999) v = 9999;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_load();
    m_left  = 12'd0;
    m_score = 16'h0000;
    for (int r = 0; r < ROWS; r++) begin
      model_map[r] = rom_data(r);
      m_left = m_left + 12'($countones(model_map[r]));
    end
  endtask

  task automatic read_row(input int idx);
    logic [79:0] e;
    fm_bus.food_idx_y = 6'(idx);
    e = '0;
    if (m_running && idx < ROWS) e = model_map[idx];
    row_q.push_back(e);
    @(negedge clk);
    e = row_q.pop_front();
    n_checks++;
    if (fm_bus.food_row !== e) begin
      n_fail++;
      $display("FAIL food_row[%0d]: got %h expected %h", idx, fm_bus.food_row, e);
    end
  endtask

  task automatic eat(input int x, input int y);
    int tx, ty;
    logic valid;
    logic [1:0]  exp_st;
    logic [27:0] e;
    tx = (x + 8) >> 4;
    ty = (y + 8) >> 4;
    valid = (tx < COLS) && (ty < ROWS);
    if (valid && model_map[ty][tx]) begin
      model_map[ty][tx] = 1'b0;
      m_score = score_plus_one(m_score);
      if (m_left != 12'd0) m_left = m_left - 12'd1;
    end
    eat_q.push_back({m_score, m_left});
    exp_st = valid ? ST_EAT : ST_RUN;
    fm_bus.pacman_blkpos_x = 11'(x);
    fm_bus.pacman_blkpos_y = 10'(y);
    fm_bus.eat_tick = 1'b1;
    @(negedge clk);
    fm_bus.eat_tick = 1'b0;
    n_checks++;
    if (fm_bus.fsm_state !== exp_st) begin
      n_fail++;
      $display("FAIL eat_state (%0d,%0d): got %0d expected %0d", tx, ty, fm_bus.fsm_state, exp_st);
    end
    @(negedge clk);
    e = eat_q.pop_front();
    n_checks++;
    if ({fm_bus.score, fm_bus.food_left} !== e) begin
      n_fail++;
      $display("FAIL eat_result (%0d,%0d): got score %h left %0d expected score %h left %0d",
               tx, ty, fm_bus.score, fm_bus.food_left, e[27:12], e[11:0]);
    end
  endtask

  task automatic do_restart(input int mode);
    rom_mode = mode;
    fm_bus.restart = 1'b1;
    @(negedge clk);
    fm_bus.restart = 1'b0;
    m_running = 1'b0;
    model_load();
  endtask

  task automatic wait_load(input string tag);
    int cycles;
    cycles = 0;
    while (!fm_bus.init_done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    m_running = fm_bus.init_done;
    n_checks++;
    if (cycles != 51) begin
      n_fail++;
      $display("FAIL %s load_cycles: got %0d expected 51", tag, cycles);
    end
    n_checks++;
    if (fm_bus.food_left !== m_left) begin
      n_fail++;
      $display("FAIL %s food_left: got %0d expected %0d", tag, fm_bus.food_left, m_left);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({fm_bus.fsm_state, fm_bus.map_idx_y, fm_bus.score, fm_bus.food_left,
         fm_bus.init_done, fm_bus.all_eaten} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: st %0d idx %0d score %h left %0d done %b all %b expected zeros",
               fm_bus.fsm_state, fm_bus.map_idx_y, fm_bus.score, fm_bus.food_left,
               fm_bus.init_done, fm_bus.all_eaten);
    end
    n_checks++;
    if (fm_bus.food_row !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_food_row: got %h expected 0", fm_bus.food_row);
    end
  endtask

  task automatic test_load();
    rom_mode = 0;
    model_load();
    rst_n = 1'b1;
    wait_load("initial");
    n_checks++;
    if (fm_bus.fsm_state !== ST_RUN || fm_bus.all_eaten !== 1'b0) begin
      n_fail++;
      $display("FAIL load_state: got st %0d all_eaten %b expected 1 0", fm_bus.fsm_state, fm_bus.all_eaten);
    end
    read_row(3);
    read_row(49);
    read_row(50);
    read_row(63);
  endtask

  task automatic test_eat_basic();
    do_restart(1);
    wait_load("full_map");
    eat(80, 112);
    read_row(7);
    eat(80, 112);
    read_row(7);
  endtask

  task automatic test_score_carry();
    for (int i = 0; i < 98; i++) eat((10 + i % 60) * 16, (20 + i / 60) * 16);
    n_checks++;
    if (fm_bus.score !== 16'h0099) begin
      n_fail++;
      $display("FAIL score_0099: got %h expected 0099", fm_bus.score);
    end
    eat(12 * 16, 30 * 16);
    n_checks++;
    if (fm_bus.score !== 16'h0100) begin
      n_fail++;
      $display("FAIL score_0100: got %h expected 0100", fm_bus.score);
    end
    force fm_bus.score = 16'h9999;
    @(negedge clk);
    release fm_bus.score;
    m_score = 16'h9999;
    eat(75 * 16, 45 * 16);
    n_checks++;
    if (fm_bus.score !== 16'h9999) begin
      n_fail++;
      $display("FAIL score_saturate: got %h expected 9999", fm_bus.score);
    end
  endtask

  task automatic test_ignored_ticks();
    logic [27:0] e;
    eat(1279, 112);
    // Second tick arrives while the first is in EAT and must be dropped.
    model_map[46][76] = 1'b0;
    m_score = score_plus_one(m_score);
    m_left  = m_left - 12'd1;
    eat_q.push_back({m_score, m_left});
    fm_bus.pacman_blkpos_x = 11'(76 * 16);
    fm_bus.pacman_blkpos_y = 10'(46 * 16);
    fm_bus.eat_tick = 1'b1;
    @(negedge clk);
    fm_bus.pacman_blkpos_x = 11'(77 * 16);
    @(negedge clk);
    fm_bus.eat_tick = 1'b0;
    @(negedge clk);
    e = eat_q.pop_front();
    n_checks++;
    if ({fm_bus.score, fm_bus.food_left} !== e) begin
      n_fail++;
      $display("FAIL eat_during_eat: got score %h left %0d expected score %h left %0d",
               fm_bus.score, fm_bus.food_left, e[27:12], e[11:0]);
    end
    read_row(46);
  endtask

  task automatic test_restart();
    int cycles;
    int bad_row;
    do_restart(0);
    wait_load("mode0");
    for (int r = 0; r < 42; r++) eat(r * 16, r * 16);
    n_checks++;
    if (fm_bus.score !== 16'h0042) begin
      n_fail++;
      $display("FAIL score_0042: got %h expected 0042", fm_bus.score);
    end
    fm_bus.pacman_blkpos_x = 11'(45 * 16);
    fm_bus.pacman_blkpos_y = 10'(45 * 16);
    fm_bus.eat_tick = 1'b1;
    fm_bus.food_idx_y = 6'd3;
    do_restart(0);
    n_checks++;
    if ({fm_bus.fsm_state, fm_bus.score, fm_bus.food_left, fm_bus.init_done} !== '0) begin
      n_fail++;
      $display("FAIL restart_entry: got st %0d score %h left %0d done %b expected zeros",
               fm_bus.fsm_state, fm_bus.score, fm_bus.food_left, fm_bus.init_done);
    end
    cycles = 0;
    bad_row = 0;
    while (!fm_bus.init_done && cycles < 200) begin
      if (fm_bus.food_row !== 80'h0 || fm_bus.score !== 16'h0000) bad_row++;
      fm_bus.eat_tick = (cycles % 3 == 0);
      @(negedge clk);
      cycles++;
    end
    fm_bus.eat_tick = 1'b0;
    m_running = fm_bus.init_done;
    n_checks++;
    if (bad_row != 0 || cycles != 51) begin
      n_fail++;
      $display("FAIL restart_load: got %0d nonzero samples and %0d cycles expected 0 and 51", bad_row, cycles);
    end
    n_checks++;
    if (fm_bus.food_left !== m_left || fm_bus.score !== 16'h0000) begin
      n_fail++;
      $display("FAIL restart_recount: got left %0d score %h expected %0d 0000",
               fm_bus.food_left, fm_bus.score, m_left);
    end
    read_row(45);
    read_row(0);
  endtask

  task automatic test_reset_mid_load();
    int cycles;
    do_restart(0);
    cycles = 0;
    while (fm_bus.map_idx_y != 6'd20 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (fm_bus.map_idx_y !== 6'd20) begin
      n_fail++;
      $display("FAIL reach_row20: got %0d expected 20", fm_bus.map_idx_y);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fm_bus.fsm_state, fm_bus.map_idx_y, fm_bus.score, fm_bus.food_left,
         fm_bus.init_done, fm_bus.all_eaten, fm_bus.food_row} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got idx %0d left %0d score %h expected zeros",
               fm_bus.map_idx_y, fm_bus.food_left, fm_bus.score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_load();
    wait_load("after_reset");
    for (int r = 0; r < ROWS; r++) eat(r * 16, r * 16);
    n_checks++;
    if (fm_bus.food_left !== 12'd0 || fm_bus.all_eaten !== 1'b0) begin
      n_fail++;
      $display("FAIL last_eat: got left %0d all_eaten %b expected 0 0", fm_bus.food_left, fm_bus.all_eaten);
    end
    @(negedge clk);
    n_checks++;
    if (fm_bus.all_eaten !== 1'b1) begin
      n_fail++;
      $display("FAIL all_eaten: got %b expected 1", fm_bus.all_eaten);
    end
  endtask

  initial begin
    fm_bus.restart         = 1'b0;
    fm_bus.eat_tick        = 1'b0;
    fm_bus.food_idx_y      = 6'd0;
    fm_bus.pacman_blkpos_x = 11'd0;
    fm_bus.pacman_blkpos_y = 10'd0;
    test_reset();
    test_load();
    test_eat_basic();
    test_score_carry();
    test_ignored_ticks();
    test_restart();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
